traffic_gen: RTL and testbench
==============================

Name: traffic_gen

Overview:
Hardware traffic source that sits directly upstream of the switch's ingress ports. During an experiment it drives the shared ingress metadata bus and the per-port write strobes in place of software writes, so offered load is cycle-exact and repeatable. An LFSR sets the per-port injection probability and the random destinations. Its outputs are muxed with the software interface's ingress write path.

Parameters:
NUM_PORTS, 4, number of ingress ports served (fixed at 4 for this revision).
SEQ_W, 16, width of the per-port sequence counter.
SLOT_LEN, 16, cycles per generator round; matches the switch's 16-cycle schedule cycle.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; samples configuration and begins a run
stop  in  1  single-cycle pulse; aborts the run
seed  in  16  LFSR seed, sampled on start
rate  in  32  four 8-bit injection thresholds; port i uses rate[8i+7:8i]; sampled on start
dst_mode  in  1  0 = uniform random destination, 1 = fixed permutation (dst = (src+1) mod 4); sampled on start
num_pkts  in  16  packets per port; 0 = unlimited until stop; sampled on start
gen_out_en  out  4  one-hot write strobe to ingress i
gen_out  out  32  metadata word: [31:30] dst, [29:28] src, [27:16] zero, [15:0] seq
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when every port has sent num_pkts
total_sent  out  32  packets emitted since last start; saturates at 0xFFFF_FFFF

Behaviour:
- Reset values: gen_out_en=0, gen_out=0, busy=0, done=0, total_sent=0. FSM returns to IDLE; slot counter, LFSR and all per-port counters clear.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on start (and no stop).
  - RUN -> IDLE on stop, or when all ports are complete.
  - start while in RUN is ignored.
  - start and stop in the same cycle: stop wins, and the FSM stays in or returns to IDLE.
- On start, at clock edge T:
  - Latch the configuration.
  - Load LFSR = seed; a seed of 0 is replaced with 0xACE1.
  - Clear the per-port seq and remaining counters, total_sent, and slot.
- slot counter: counts 0..SLOT_LEN-1 in RUN, wraps to 0, and is held at 0 in IDLE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400), shifting right once every RUN cycle.
- Decision rule: in a RUN cycle with slot = p < 4, port p fires iff all of the following hold:
  - rate_p == 0xFF, or lfsr[7:0] < rate_p;
  - port p is not complete;
  - stop is not asserted this cycle.
  - Slots 4..15 never fire. This gives at most one strobe per cycle, which is required because the metadata bus is shared.
- Destination: lfsr[9:8] when dst_mode=0; (p+1) mod 4 when dst_mode=1. Self-destination is allowed in mode 0.
- Outputs are registered. A firing decision in cycle c produces gen_out_en = (1<<p) and the matching gen_out during cycle c+1, for exactly one cycle. gen_out_en=0 otherwise; gen_out holds its last value.
- On each emit:
  - seq_p increments and wraps at 2^SEQ_W.
  - total_sent increments, saturating.
  - remaining_p decrements when num_pkts≠0.
  - Port p is complete when remaining_p reaches 0. A port is never complete when num_pkts=0.
- Completion:
  - When the final emit makes all four ports complete, done pulses in the same cycle that the final strobe is visible.
  - busy drops in that same cycle.
  - A port with rate 0 never completes, so the run only ends on stop.
- stop mid-run: no strobe appears in the following cycle, busy=0 next cycle, done is not pulsed, and total_sent retains its value.
- reset mid-run overrides everything with the reset values in the next cycle.
- total_sent is readable in IDLE and is cleared only by start or reset.

Test Plan:
- Reset, then start at edge T with rate=0xFFFFFFFF, dst_mode=1, num_pkts=3, seed=1 -> busy=1 from T+1. Strobes 0001/0010/0100/1000 in cycles T+2..T+5, repeating at T+18 and T+34. First word is 0x4000_0000; port 3 seq 2 is 0x3000_0002. done pulses with the last strobe at T+37; total_sent=12; busy=0.
- rate=0x00000000, num_pkts=5, start -> no strobes over 200 cycles, busy stays 1. Then pulse stop -> busy=0 next cycle, done never pulses, total_sent=0.
- rate=0x000000FF (port 0 only), num_pkts=0, dst_mode=0, seed=0 -> LFSR loads 0xACE1. Only gen_out_en=0001 appears, once per 16 cycles. gen_out[31:30] matches the reference-model lfsr[9:8] and seq increments 0,1,2,...
- Run with rate=0x80808080 and seed=0x1234 for 1600 cycles, compared cycle-by-cycle against a reference model -> total_sent and the strobe trace match exactly, and gen_out_en is never multi-hot.
- start and stop in the same cycle from IDLE -> remains IDLE with no strobes. start pulsed again during RUN -> ignored, no counter clear.
- Assert reset two cycles after start -> all outputs return to their reset values the next cycle, and the FSM is in IDLE.

Source files
------------

// File: rtl/traffic_gen_if.sv
// Control and metadata bus between the experiment controller and traffic_gen.
// The master side configures and starts a run. The slave side is the generator,
// which drives the shared ingress metadata bus and the per-port write strobes.
interface traffic_gen_if;
  logic        start;
  logic        stop;
  logic [15:0] seed;
  logic [31:0] rate;
  logic        dst_mode;
  logic [15:0] num_pkts;
  logic [3:0]  gen_out_en;
  logic [31:0] gen_out;
  logic        busy;
  logic        done;
  logic [31:0] total_sent;

  modport master (
    output start, stop, seed, rate, dst_mode, num_pkts,
    input  gen_out_en, gen_out, busy, done, total_sent
  );

  modport slave (
    input  start, stop, seed, rate, dst_mode, num_pkts,
    output gen_out_en, gen_out, busy, done, total_sent
  );
endinterface

// File: rtl/traffic_gen.sv
// Cycle-exact ingress traffic source. A 16-cycle round gives each port one
// decision slot, which keeps the shared metadata bus to one strobe per cycle.
// An LFSR supplies both the injection coin-flip and the random destinations.

// Per-port bookkeeping: sequence number and packets still to send.
module traffic_gen_port #(
  parameter int SEQ_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             fire,
  input  logic             limited,
  input  logic [CNT_W-1:0] num_pkts,
  output logic [SEQ_W-1:0] seq,
  output logic             complete,
  output logic             last
);
  logic [CNT_W-1:0] remaining;

  // Reload on start; count one packet per emit
  always_ff @(posedge clk) begin
    if (reset) begin
      seq       <= '0;
      remaining <= '0;
    end else if (clear) begin
      seq       <= '0;
      remaining <= num_pkts;
    end else if (fire) begin
      seq <= seq + SEQ_W'(1);
      if (limited) remaining <= remaining - CNT_W'(1);
    end
  end

  // An unlimited run (num_pkts == 0) never completes
  assign complete = limited && (remaining == '0);
  assign last     = limited && (remaining == CNT_W'(1));
endmodule

module traffic_gen #(
  parameter int NUM_PORTS = 4,
  parameter int SEQ_W     = 16,
  parameter int SLOT_LEN  = 16
) (
  input  logic          clk,
  input  logic          reset,
  traffic_gen_if.slave  bus
);
  localparam int          SLOT_W    = $clog2(SLOT_LEN);
  localparam int          PORT_W    = $clog2(NUM_PORTS);
  localparam logic [15:0] SEED_ALT  = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state;
  logic [SLOT_W-1:0]               slot;
  logic [15:0]                     lfsr;
  logic [15:0]                     lfsr_next;
  logic [31:0]                     rate_q;
  logic                            dst_mode_q;
  logic [15:0]                     num_pkts_q;

  logic [NUM_PORTS-1:0]            gen_out_en_q;
  logic [31:0]                     gen_out_q;
  logic                            busy_q;
  logic                            done_q;
  logic [31:0]                     total_q;

  logic [NUM_PORTS-1:0][SEQ_W-1:0] seq;
  logic [NUM_PORTS-1:0]            complete;
  logic [NUM_PORTS-1:0]            last;
  logic [NUM_PORTS-1:0]            fire;

  logic [PORT_W-1:0]               port;
  logic                            port_slot;
  logic [7:0]                      rate_p;
  logic                            hit;
  logic                            fire_any;
  logic                            limited;
  logic                            start_go;
  logic                            final_emit;
  logic [PORT_W-1:0]               dst;
  logic [15:0]                     seq_field;
  logic [31:0]                     word;

  // Only the first NUM_PORTS slots of a round carry a decision
  assign port      = slot[PORT_W-1:0];
  assign port_slot = (slot < SLOT_W'(NUM_PORTS));
  assign rate_p    = rate_q[8*port +: 8];
  assign hit       = (rate_p == 8'hFF) || (lfsr[7:0] < rate_p);
  assign limited   = (num_pkts_q != '0);
  assign fire_any  = (state == RUN) && port_slot && hit && !complete[port] && !bus.stop;
  assign start_go  = (state == IDLE) && bus.start && !bus.stop;

  // Galois right shift, taps x^16+x^14+x^13+x^11+1
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  // Fixed permutation sends each port to its neighbour
  assign dst       = dst_mode_q ? port + PORT_W'(1) : lfsr[8 +: PORT_W];
  assign seq_field = 16'(seq[port]);
  assign word      = {dst, port, {(16 - 2*PORT_W){1'b0}}, seq_field};

  // One-hot strobe for the port owning this slot
  always_comb begin
    fire = '0;
    if (fire_any) fire[port] = 1'b1;
  end

  // The run ends when this emit leaves every port complete
  always_comb begin
    final_emit = fire_any;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!(complete[i] || (fire[i] && last[i]))) final_emit = 1'b0;
    end
  end

  // Per-port counters, one instance per ingress port
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    traffic_gen_port #(
      .SEQ_W (SEQ_W),
      .CNT_W (16)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .clear    (start_go),
      .fire     (fire[i]),
      .limited  (limited),
      .num_pkts (bus.num_pkts),
      .seq      (seq[i]),
      .complete (complete[i]),
      .last     (last[i])
    );
  end

  // Run-control FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      slot         <= '0;
      lfsr         <= '0;
      rate_q       <= '0;
      dst_mode_q   <= 1'b0;
      num_pkts_q   <= '0;
      gen_out_en_q <= '0;
      gen_out_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      total_q      <= '0;
    end else begin
      gen_out_en_q <= fire;
      done_q       <= 1'b0;
      if (fire_any) begin
        gen_out_q <= word;
        if (total_q != 32'hFFFF_FFFF) total_q <= total_q + 32'd1;
      end
      if (state == IDLE) begin
        slot <= '0;
        if (start_go) begin
          state      <= RUN;
          busy_q     <= 1'b1;
          rate_q     <= bus.rate;
          dst_mode_q <= bus.dst_mode;
          num_pkts_q <= bus.num_pkts;
          lfsr       <= (bus.seed == '0) ? SEED_ALT : bus.seed;
          total_q    <= '0;
        end
      end else begin
        lfsr <= lfsr_next;
        if (bus.stop) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          slot   <= '0;
        end else if (final_emit) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          slot   <= '0;
        end else begin
          slot <= (slot == SLOT_W'(SLOT_LEN - 1)) ? '0 : slot + SLOT_W'(1);
        end
      end
    end
  end

  assign bus.gen_out_en = gen_out_en_q;
  assign bus.gen_out    = gen_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.total_sent = total_q;
endmodule

// File: tb/tb_traffic_gen.sv
// Directed bench for traffic_gen: fixed-permutation run, zero-rate run with
// stop, LFSR destinations, a long random trace, start/stop races and reset.
module tb_traffic_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  traffic_gen_if bus();

  traffic_gen #(.NUM_PORTS(4), .SEQ_W(16), .SLOT_LEN(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] held_total = '0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // After return the bench sits in cycle T+1 of the run
  task automatic do_start(input logic [15:0] s, input logic [31:0] r,
                          input logic d, input logic [15:0] n);
    bus.seed = s; bus.rate = r; bus.dst_mode = d; bus.num_pkts = n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_stop;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (bus.gen_out_en !== 4'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0000", bus.gen_out_en); end
    n_checks++; if (bus.gen_out !== 32'h0) begin n_fail++; $display("FAIL reset_gen_out: got %h expected 0", bus.gen_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.total_sent !== 32'h0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", bus.total_sent); end
    reset = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_fixed_perm;
    logic [3:0] e_en;
    do_start(16'h0001, 32'hFFFF_FFFF, 1'b1, 16'd3);
    for (int k = 1; k <= 40; k++) begin
      e_en = 4'b0;
      if (k >= 2 && k <= 5)   e_en = 4'b0001 << (k - 2);
      if (k >= 18 && k <= 21) e_en = 4'b0001 << (k - 18);
      if (k >= 34 && k <= 37) e_en = 4'b0001 << (k - 34);
      n_checks++; if (bus.gen_out_en !== e_en) begin n_fail++; $display("FAIL perm_en T+%0d: got %b expected %b", k, bus.gen_out_en, e_en); end
      n_checks++; if (bus.busy !== (k <= 36)) begin n_fail++; $display("FAIL perm_busy T+%0d: got %b expected %b", k, bus.busy, (k <= 36)); end
      n_checks++; if (bus.done !== (k == 37)) begin n_fail++; $display("FAIL perm_done T+%0d: got %b expected %b", k, bus.done, (k == 37)); end
      if (k == 2) begin
        n_checks++; if (bus.gen_out !== 32'h4000_0000) begin n_fail++; $display("FAIL perm_first_word: got %h expected 40000000", bus.gen_out); end
      end
      if (k == 37) begin
        n_checks++; if (bus.gen_out !== 32'h3000_0002) begin n_fail++; $display("FAIL perm_last_word: got %h expected 30000002", bus.gen_out); end
      end
      if (k == 38) begin
        n_checks++; if (bus.total_sent !== 32'd12) begin n_fail++; $display("FAIL perm_total: got %0d expected 12", bus.total_sent); end
      end
      tick();
    end
  endtask

  task automatic test_zero_rate;
    int bad_en, bad_busy, bad_done;
    bad_en = 0; bad_busy = 0; bad_done = 0;
    do_start(16'h0055, 32'h0000_0000, 1'b0, 16'd5);
    for (int k = 1; k <= 200; k++) begin
      if (bus.gen_out_en !== 4'b0) bad_en++;
      if (bus.busy !== 1'b1) bad_busy++;
      tick();
    end
    n_checks++; if (bad_en != 0) begin n_fail++; $display("FAIL zero_rate_strobes: got %0d strobe cycles expected 0", bad_en); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL zero_rate_busy: got %0d idle cycles expected 0", bad_busy); end
    do_stop();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_rate_stop_busy: got %b expected 0", bus.busy); end
    for (int k = 0; k < 20; k++) begin
      if (bus.done !== 1'b0) bad_done++;
      tick();
    end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL zero_rate_done: got %0d done pulses expected 0", bad_done); end
    n_checks++; if (bus.total_sent !== 32'd0) begin n_fail++; $display("FAIL zero_rate_total: got %0d expected 0", bus.total_sent); end
  endtask

  // Port 0 only, random destinations, seed 0 replaced by 0xACE1
  task automatic test_lfsr_dst;
    logic [15:0] m;
    logic [3:0]  e_en;
    logic [31:0] e_word;
    logic [15:0] sq;
    int          cnt;
    m = 16'hACE1; e_en = 4'b0; e_word = '0; sq = '0; cnt = 0;
    do_start(16'h0000, 32'h0000_00FF, 1'b0, 16'd0);
    for (int k = 1; k <= 100; k++) begin
      n_checks++; if (bus.gen_out_en !== e_en) begin n_fail++; $display("FAIL lfsr_en T+%0d: got %b expected %b", k, bus.gen_out_en, e_en); end
      if (e_en != 4'b0) begin
        n_checks++; if (bus.gen_out !== e_word) begin n_fail++; $display("FAIL lfsr_word T+%0d: got %h expected %h", k, bus.gen_out, e_word); end
      end
      e_en = 4'b0;
      if ((k - 1) % 16 == 0) begin
        e_en = 4'b0001;
        e_word = {m[9:8], 2'd0, 12'd0, sq};
        sq++; cnt++;
      end
      m = lfsr_step(m);
      tick();
    end
    do_stop();
    n_checks++; if (bus.total_sent !== 32'(cnt)) begin n_fail++; $display("FAIL lfsr_total: got %0d expected %0d", bus.total_sent, cnt); end
  endtask

  task automatic test_random_trace;
    logic [15:0]      m;
    logic [3:0]       e_en;
    logic [31:0]      e_word;
    logic [3:0][15:0] sq;
    logic [31:0]      r;
    logic [7:0]       rp;
    int               cnt, slot;
    m = 16'h1234; e_en = 4'b0; e_word = '0; sq = '0; cnt = 0;
    r = 32'h8080_8080;
    do_start(16'h1234, r, 1'b0, 16'd0);
    for (int k = 1; k <= 1600; k++) begin
      n_checks++; if (bus.gen_out_en !== e_en) begin n_fail++; $display("FAIL rand_en T+%0d: got %b expected %b", k, bus.gen_out_en, e_en); end
      n_checks++; if ($countones(bus.gen_out_en) > 1) begin n_fail++; $display("FAIL rand_onehot T+%0d: got %b expected at most one bit", k, bus.gen_out_en); end
      if (e_en != 4'b0) begin
        n_checks++; if (bus.gen_out !== e_word) begin n_fail++; $display("FAIL rand_word T+%0d: got %h expected %h", k, bus.gen_out, e_word); end
      end
      e_en = 4'b0;
      slot = (k - 1) % 16;
      if (slot < 4) begin
        rp = r[8*slot +: 8];
        if (rp == 8'hFF || m[7:0] < rp) begin
          e_en = 4'b0001 << slot;
          e_word = {m[9:8], 2'(slot), 12'd0, sq[slot]};
          sq[slot] = sq[slot] + 16'd1;
          cnt++;
        end
      end
      m = lfsr_step(m);
      tick();
    end
    n_checks++; if (bus.gen_out_en !== e_en) begin n_fail++; $display("FAIL rand_en_tail: got %b expected %b", bus.gen_out_en, e_en); end
    do_stop();
    n_checks++; if (bus.gen_out_en !== 4'b0) begin n_fail++; $display("FAIL rand_stop_en: got %b expected 0000", bus.gen_out_en); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_stop_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.total_sent !== 32'(cnt)) begin n_fail++; $display("FAIL rand_total: got %0d expected %0d", bus.total_sent, cnt); end
    held_total = 32'(cnt);
  endtask

  task automatic test_start_stop_same;
    int bad;
    bad = 0;
    bus.seed = 16'h0001; bus.rate = 32'hFFFF_FFFF; bus.dst_mode = 1'b1; bus.num_pkts = 16'd3;
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.gen_out_en !== 4'b0 || bus.busy !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL same_cycle_idle: got %0d active cycles expected 0", bad); end
    n_checks++; if (bus.total_sent !== held_total) begin n_fail++; $display("FAIL same_cycle_total: got %0d expected %0d", bus.total_sent, held_total); end
  endtask

  task automatic test_restart_ignored;
    logic [3:0] e_en;
    do_start(16'h0001, 32'hFFFF_FFFF, 1'b1, 16'd3);
    for (int k = 1; k <= 40; k++) begin
      e_en = 4'b0;
      if (k >= 2 && k <= 5)   e_en = 4'b0001 << (k - 2);
      if (k >= 18 && k <= 21) e_en = 4'b0001 << (k - 18);
      if (k >= 34 && k <= 37) e_en = 4'b0001 << (k - 34);
      n_checks++; if (bus.gen_out_en !== e_en) begin n_fail++; $display("FAIL restart_en T+%0d: got %b expected %b", k, bus.gen_out_en, e_en); end
      n_checks++; if (bus.done !== (k == 37)) begin n_fail++; $display("FAIL restart_done T+%0d: got %b expected %b", k, bus.done, (k == 37)); end
      if (k == 11) begin
        n_checks++; if (bus.total_sent !== 32'd4) begin n_fail++; $display("FAIL restart_no_clear: got %0d expected 4", bus.total_sent); end
      end
      if (k == 38) begin
        n_checks++; if (bus.total_sent !== 32'd12) begin n_fail++; $display("FAIL restart_total: got %0d expected 12", bus.total_sent); end
      end
      if (k == 10) begin
        bus.rate = 32'h0; bus.num_pkts = 16'd1; bus.seed = 16'h0009; bus.start = 1'b1;
      end
      if (k == 11) bus.start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midrun;
    int bad;
    bad = 0;
    do_start(16'h0001, 32'hFFFF_FFFF, 1'b1, 16'd3);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy); end
    tick();
    n_checks++; if (bus.gen_out_en !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_en: got %b expected 0001", bus.gen_out_en); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus.gen_out_en !== 4'b0) begin n_fail++; $display("FAIL midrst_en: got %b expected 0000", bus.gen_out_en); end
    n_checks++; if (bus.gen_out !== 32'h0) begin n_fail++; $display("FAIL midrst_gen_out: got %h expected 0", bus.gen_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.total_sent !== 32'h0) begin n_fail++; $display("FAIL midrst_total: got %0d expected 0", bus.total_sent); end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.gen_out_en !== 4'b0 || bus.busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_idle: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.seed = '0;
    bus.rate = '0; bus.dst_mode = 1'b0; bus.num_pkts = '0;
    test_reset();
    test_fixed_perm();
    test_zero_rate();
    test_lfsr_dst();
    test_random_trace();
    test_start_stop_same();
    test_restart_ignored();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
